// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and refill-side signals of the direct-mapped instruction cache.
// The cache takes the master modport; the PC/memory environment takes slave.
//
// Refill handshake: mem_req is held high with mem_address stable until a
// cycle in which mem_ack is 1; each such cycle transfers exactly one beat on
// mem_rdata. mem_ack without mem_req carries no data and is ignored. Dropping
// mem_req before the last beat cancels the refill.
interface icache_direct_mapped_if;
    logic        invalidate;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_address;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  invalidate,
        input  address,
        input  mem_rdata,
        input  mem_ack,
        output instruction,
        output hit,
        output mem_req,
        output mem_address
    );

    modport slave (
        output invalidate,
        output address,
        output mem_rdata,
        output mem_ack,
        input  instruction,
        input  hit,
        input  mem_req,
        input  mem_address
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: combinational lookup of the fetch address,
// 4-word line refill from instruction memory when the lookup misses.
// dbg_state is 1 while the refill FSM is in REFILL.
module icache_direct_mapped #(
    parameter int INDEX_BITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    icache_direct_mapped_if.master bus,
    output logic                   dbg_state
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - 4 - INDEX_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Fetch address fields
    logic [TAG_BITS-1:0]   a_tag;
    logic [INDEX_BITS-1:0] a_idx;
    logic [1:0]            a_word;

    assign a_word = bus.address[3:2];
    assign a_idx  = bus.address[3+INDEX_BITS:4];
    assign a_tag  = bus.address[31:4+INDEX_BITS];

    // Line storage
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES][4];

    // Control state
    state_e                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [TAG_BITS-1:0]   lat_tag_q, lat_tag_d;
    logic [INDEX_BITS-1:0] lat_idx_q, lat_idx_d;
    logic                  mem_req_q, mem_req_d;
    logic [31:0]           mem_address_q, mem_address_d;

    // Array write strobes
    logic fill_we;
    logic line_done;
    logic clr_valid;
    logic flush;
    logic lookup_hit;

    // Lookup: only trusted in IDLE, since a refilling line is partially written
    always_comb begin
        lookup_hit      = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
        bus.hit         = (state_q == IDLE) && lookup_hit;
        bus.instruction = data_q[a_idx][a_word];
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_address = mem_address_q;
    assign dbg_state       = (state_q == REFILL);

    // Next-state logic: miss detection, beat sequencing, invalidate override
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        lat_tag_d     = lat_tag_q;
        lat_idx_d     = lat_idx_q;
        mem_req_d     = mem_req_q;
        mem_address_d = mem_address_q;
        fill_we       = 1'b0;
        line_done     = 1'b0;
        clr_valid     = 1'b0;
        flush         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!lookup_hit) begin
                    // The victim line is invalidated up front so a cancelled
                    // refill can never leave a half-written line looking valid.
                    lat_tag_d     = a_tag;
                    lat_idx_d     = a_idx;
                    beat_d        = 2'd0;
                    clr_valid     = 1'b1;
                    state_d       = REFILL;
                    mem_req_d     = 1'b1;
                    mem_address_d = {a_tag, a_idx, 2'd0, 2'b00};
                end
            end
            REFILL: begin
                if (bus.mem_ack) begin
                    fill_we = 1'b1;
                    beat_d  = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        line_done     = 1'b1;
                        state_d       = IDLE;
                        mem_req_d     = 1'b0;
                        mem_address_d = 32'd0;
                    end else begin
                        mem_address_d = {lat_tag_q, lat_idx_q, beat_d, 2'b00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.invalidate) begin
            flush         = 1'b1;
            fill_we       = 1'b0;
            line_done     = 1'b0;
            clr_valid     = 1'b0;
            state_d       = IDLE;
            beat_d        = 2'd0;
            mem_req_d     = 1'b0;
            mem_address_d = 32'd0;
        end
    end

    // State and array update; reset wins over invalidate, which wins over the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            beat_q        <= 2'd0;
            mem_req_q     <= 1'b0;
            mem_address_q <= 32'd0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            lat_tag_q     <= lat_tag_d;
            lat_idx_q     <= lat_idx_d;
            mem_req_q     <= mem_req_d;
            mem_address_q <= mem_address_d;

            if (flush) begin
                valid_q <= '0;
            end else begin
                if (clr_valid) begin
                    valid_q[lat_idx_d] <= 1'b0;
                end
                if (line_done) begin
                    valid_q[lat_idx_q] <= 1'b1;
                end
            end

            if (fill_we) begin
                data_q[lat_idx_q][beat_q] <= bus.mem_rdata;
            end
            if (line_done) begin
                tag_q[lat_idx_q] <= lat_tag_q;
            end
        end
    end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: a memory driver answers refill
// beats, a monitor compares every acked beat address against the expected
// queue, and the stimulus checks hit timing and returned instructions.
module tb_icache_direct_mapped;
  logic clk = 1'b0;
  logic reset;
  logic dbg_state;

  icache_direct_mapped_if cif();

  icache_direct_mapped #(.INDEX_BITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (cif),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int wait_n   = 0;

  // memory contents: a fixed function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // all stimulus and checks happen 2 time units after the falling edge
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_line(input logic [31:0] addr);
    for (int b = 0; b < 4; b++) exp_q.push_back({addr[31:4], 4'(b * 4)});
  endtask

  task automatic access_miss(input string name, input logic [31:0] addr, input int lat);
    push_line(addr);
    cif.address = addr;
    #1;
    check({name, "_miss"}, 32'(cif.hit), 32'd0);
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (i == lat - 1) check({name, "_stall"}, 32'(cif.hit), 32'd0);
    end
    check({name, "_hit"}, 32'(cif.hit), 32'd1);
    check({name, "_data"}, cif.instruction, mem_word({addr[31:2], 2'b00}));
  endtask

  task automatic wait_addr(input string name, input logic [31:0] target);
    int found;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (cif.mem_address === target) found = 1;
      else tick();
    end
    check({name, "_reached"}, 32'(found), 32'd1);
  endtask

  // memory driver: acks one beat per request, with wait_n idle cycles between beats
  initial begin
    int gap;
    gap = 0;
    cif.mem_ack   = 1'b0;
    cif.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (cif.mem_req) begin
        if (gap == 0) begin
          cif.mem_ack   = 1'b1;
          cif.mem_rdata = mem_word(cif.mem_address);
          gap = wait_n;
        end else begin
          cif.mem_ack   = 1'b0;
          cif.mem_rdata = 32'd0;
          gap--;
        end
      end else begin
        cif.mem_ack   = 1'b0;
        cif.mem_rdata = 32'd0;
        gap = 0;
      end
    end
  end

  // monitor: every acked beat must match the next expected beat address
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (cif.mem_req === 1'b1 && cif.mem_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected_beat: got 0x%08h expected no request", cif.mem_address);
        end else begin
          e = exp_q.pop_front();
          check("sb_beat_addr", cif.mem_address, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cif.invalidate = 1'b0;
    cif.address = 32'd0;
    repeat (3) tick();
    check("reset_hit", 32'(cif.hit), 32'd0);
    check("reset_req", 32'(cif.mem_req), 32'd0);
    check("reset_maddr", cif.mem_address, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);

    // first miss with zero-wait memory
    reset = 1'b0;
    access_miss("fill40", 32'h0000_0040, 5);

    // same line, other word: immediate hit, no request
    cif.address = 32'h0000_0048;
    #1;
    check("hit48_hit", 32'(cif.hit), 32'd1);
    check("hit48_data", cif.instruction, mem_word(32'h0000_0048));
    tick();
    check("hit48_noreq", 32'(cif.mem_req), 32'd0);
    check("hit48_still", 32'(cif.hit), 32'd1);

    // conflict on index 4
    access_miss("conf_c0", 32'h0000_00C0, 5);
    access_miss("conf_40", 32'h0000_0040, 5);

    // wait states and address toggled mid-refill
    wait_n = 2;
    push_line(32'h1000_0100);
    cif.address = 32'h1000_0100;
    #1;
    check("ws_miss", 32'(cif.hit), 32'd0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 2) cif.address = 32'h0000_0080;
      if (i == 7) cif.address = 32'h1000_0100;
      if (i == 2 || i == 3) check("ws_hold_addr", cif.mem_address, 32'h1000_0104);
      if (i == 3) check("ws_hold_req", 32'(cif.mem_req), 32'd1);
      if (i == 10) check("ws_stall", 32'(cif.hit), 32'd0);
    end
    check("ws_hit", 32'(cif.hit), 32'd1);
    check("ws_data", cif.instruction, mem_word(32'h1000_0100));
    cif.address = 32'h1000_010C;
    #1;
    check("ws_data_w3", cif.instruction, mem_word(32'h1000_010C));
    wait_n = 0;

    // invalidate during beat 2
    push_line(32'h0000_0260);
    cif.address = 32'h0000_0260;
    wait_addr("inv", 32'h0000_0268);
    cif.invalidate = 1'b1;
    tick();
    cif.invalidate = 1'b0;
    check("inv_req", 32'(cif.mem_req), 32'd0);
    check("inv_state", 32'(dbg_state), 32'd0);
    check("inv_hit", 32'(cif.hit), 32'd0);
    exp_q.delete();
    access_miss("inv_260", 32'h0000_0260, 5);
    access_miss("inv_40", 32'h0000_0040, 5);
    access_miss("inv_100", 32'h1000_0100, 5);

    // reset during beat 2, then a stray ack
    push_line(32'h0000_0380);
    cif.address = 32'h0000_0380;
    wait_addr("rst", 32'h0000_0388);
    reset = 1'b1;
    tick();
    check("rst_req", 32'(cif.mem_req), 32'd0);
    check("rst_maddr", cif.mem_address, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_hit", 32'(cif.hit), 32'd0);
    exp_q.delete();
    push_line(32'h0000_0380);
    reset = 1'b0;
    cif.mem_ack = 1'b1;
    cif.mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("rst_beat0_addr", cif.mem_address, 32'h0000_0380);
    check("rst_beat0_req", 32'(cif.mem_req), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      if (i == 4) check("rst_stall", 32'(cif.hit), 32'd0);
    end
    check("rst_hit_after", 32'(cif.hit), 32'd1);
    check("rst_data", cif.instruction, mem_word(32'h0000_0380));

    tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/icache_direct_mapped.md
# icache_direct_mapped

Direct-mapped instruction cache between the program counter and the instruction memory. Looks up the current fetch address combinationally, returns the instruction and a `hit` flag, and on a miss refills a 4-word line from memory through a req/ack handshake. The PC register advances only while `hit` is 1, so the refill FSM stalls the fetch stage for the duration of each refill.

## Interface
- `INDEX_BITS`, 3: number of line-index bits; the cache holds 2^INDEX_BITS lines of 4 × 32-bit words.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `invalidate`  in  1  synchronous flush of all valid bits.
- `address`  in  32  fetch byte address from the PC; bits [1:0] are ignored.
- `instruction`  out  32  cached word selected by `address` (combinational).
- `hit`  out  1  1 when `instruction` is valid for `address` (combinational).
- `mem_req`  out  1  refill beat request, held until acked.
- `mem_address`  out  32  word address of the requested beat.
- `mem_rdata`  in  32  beat data, valid when `mem_ack` is 1.
- `mem_ack`  in  1  one-cycle beat acknowledge.

## Operation
- Address split: offset [1:0] ignored; word [3:2]; index [3+INDEX_BITS:4]; tag [31:4+INDEX_BITS].
- Storage per line: valid bit, tag, and 4 data words. Data and tag arrays are registers.
- FSM states: IDLE, REFILL.
- IDLE: `hit` = valid[index] & (tag[index] == address tag). `instruction` = data[index][word]. On a miss, latch the tag and index, clear valid[index], set beat = 0, and go to REFILL.
- REFILL:
  - `hit` = 0. `mem_req` = 1.
  - `mem_address` = {latched tag, latched index, beat, 2'b00}.
  - Each cycle with `mem_ack` = 1: write `mem_rdata` to data[idx][beat] and increment beat.
  - On the ack of beat 3: write the tag, set valid[idx], and go to IDLE.
  - `mem_ack` while in IDLE is ignored.
- `address` changes during REFILL do not affect the refill, which always uses the latched tag and index.
- `invalidate` (in any state): clears all valid bits and forces IDLE at the next edge. An in-flight refill is abandoned with no valid bit set, and `mem_req` drops. The memory treats a dropped `mem_req` as a cancel.
- Reset:
  - All valid bits 0, state IDLE, beat 0, `mem_req` 0, `mem_address` 0.
  - `hit` = 0 (no line is valid). `instruction` is don't-care while `hit` = 0.
  - Data and tag contents need not reset.
  - Reset mid-refill aborts the refill identically to `invalidate`.
- Priority: `reset` > `invalidate` > FSM.

## Timing
- Hit: zero-cycle latency. `hit` and `instruction` settle combinationally from `address` and the registered arrays.
- The PC samples `hit` on the falling edge, so `hit` must be stable within half a cycle of the rising edge.
- Miss:
  - Detected in the IDLE cycle. REFILL is entered at the next rising edge.
  - `mem_req` rises in the first REFILL cycle.
- Refill duration = 4 acked beats. With `mem_ack` tied to 1, REFILL lasts exactly 4 cycles.
- After the fourth ack, the next cycle is IDLE with `hit` = 1 for the same (stalled) address. Total miss penalty with zero-wait memory is 5 cycles.
- Memory wait states extend REFILL one cycle per non-acked cycle. `mem_address` and `mem_req` stay stable while waiting.
- Beat counter: 2 bits, wraps 3→0 exactly on completion.

## Test plan
- Reset, then `address` = 0x0000_0040 -> `hit` = 0. REFILL requests 0x40, 0x44, 0x48, 0x4C. With ack every cycle, `hit` = 1 five cycles after the miss, and `instruction` = the beat-0 data.
- After that refill, `address` = 0x48 -> `hit` = 1 immediately with the beat-2 data, and no `mem_req`.
- Conflict: fill 0x0000_0040, then access 0x0000_00C0 (same index, INDEX_BITS = 3) -> miss and refill. Re-access of 0x40 -> miss again.
- Wait states: ack beats with 2 idle cycles between them -> `mem_address` is held during each wait, and REFILL lasts 10 cycles. `address` toggled mid-refill does not change the refilled line.
- `invalidate` during beat 2 of a refill -> `mem_req` is 0 the next cycle and the state is IDLE. Re-access of that address misses, and every previously cached line also misses.
- `reset` asserted mid-refill -> same as the `invalidate` case. `mem_address` = 0, and a stray `mem_ack` arriving afterwards is ignored.
